// File: rtl/mesh_config_feeder_if.sv
// Host-load and mesh-configure signal bundle for mesh_config_feeder.
// master = host/mesh side, slave = the feeder itself.
interface mesh_config_feeder_if #(
  parameter int unsigned CFG_W = 11
);
  logic             load_valid;
  logic [1:0]       load_proc;
  logic [CFG_W-1:0] load_word;
  logic             load_ready;
  logic [3:0]       processor_ready_signals;
  logic [CFG_W-1:0] p0_configure;
  logic [CFG_W-1:0] p1_configure;
  logic [CFG_W-1:0] p2_configure;
  logic [CFG_W-1:0] p3_configure;
  logic [3:0]       issue;
  logic [3:0]       fifo_empty;

  modport master (
    output load_valid, load_proc, load_word, processor_ready_signals,
    input  load_ready, p0_configure, p1_configure, p2_configure, p3_configure,
           issue, fifo_empty
  );

  modport slave (
    input  load_valid, load_proc, load_word, processor_ready_signals,
    output load_ready, p0_configure, p1_configure, p2_configure, p3_configure,
           issue, fifo_empty
  );
endinterface

// File: rtl/mesh_config_feeder.sv
// Per-processor configure-word FIFOs feeding the 2x2 mesh, paced by processor ready.
// Optional per-port issue counters are enabled by MESH_CFG_FEEDER_STATS_EN.
module mesh_config_feeder #(
  parameter int unsigned CFG_W = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  mesh_config_feeder_if.slave   bus
`ifdef MESH_CFG_FEEDER_STATS_EN
  ,
  output logic [31:0]           issue_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_BUSY
  } state_t;

  state_t           state_q  [4];
  state_t           state_d  [4];
  logic [AW:0]      wr_ptr_q [4];
  logic [AW:0]      wr_ptr_d [4];
  logic [AW:0]      rd_ptr_q [4];
  logic [AW:0]      rd_ptr_d [4];
  logic [CFG_W-1:0] mem_q    [4][DEPTH];
  logic [CFG_W-1:0] mem_d    [4][DEPTH];
  logic [CFG_W-1:0] cfg_q    [4];
  logic [CFG_W-1:0] cfg_d    [4];
  logic [3:0]       issue_q, issue_d;
  logic [3:0]       empty_q, empty_d;

  logic [3:0]       empty;
  logic [3:0]       full;
  logic             load_ready;
  logic             push;
  logic [3:0]       rdy;

  assign rdy = bus.processor_ready_signals;

  // Wrap bit distinguishes full from empty when the index bits match.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]) &&
                 (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]);
    end
  end

  assign load_ready = ~full[bus.load_proc];
  assign push       = bus.load_valid && load_ready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    cfg_d    = cfg_q;
    issue_d  = '0;
    empty_d  = empty_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (push && (bus.load_proc == 2'(i))) begin
        mem_d[i][wr_ptr_q[i][AW-1:0]] = bus.load_word;
        wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
      end
      unique case (state_q[i])
        S_IDLE: begin
          if (!empty[i] && rdy[i]) begin
            cfg_d[i]    = mem_q[i][rd_ptr_q[i][AW-1:0]];
            rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            issue_d[i]  = 1'b1;
            state_d[i]  = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!rdy[i]) state_d[i] = S_BUSY;
        end
        S_BUSY: begin
          if (rdy[i]) state_d[i] = S_IDLE;
        end
        default: state_d[i] = S_IDLE;
      endcase
      empty_d[i] = (wr_ptr_d[i] == rd_ptr_d[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i]  <= S_IDLE;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cfg_q[i]    <= '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
      issue_q <= '0;
      empty_q <= '1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
      cfg_q    <= cfg_d;
      issue_q  <= issue_d;
      empty_q  <= empty_d;
    end
  end

  assign bus.load_ready   = load_ready;
  assign bus.p0_configure = cfg_q[0];
  assign bus.p1_configure = cfg_q[1];
  assign bus.p2_configure = cfg_q[2];
  assign bus.p3_configure = cfg_q[3];
  assign bus.issue        = issue_q;
  assign bus.fifo_empty   = empty_q;

`ifdef MESH_CFG_FEEDER_STATS_EN
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  // Counted on the popping edge so each field steps together with its issue pulse.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (issue_d[i] && (cnt_q[i] != 8'hFF)) cnt_d[i] = cnt_q[i] + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign issue_count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_mesh_config_feeder.sv
// Randomized and directed bench for mesh_config_feeder against a queue-based reference.
module tb_mesh_config_feeder;
  localparam int CFG_W = 11;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mesh_config_feeder_if #(.CFG_W(CFG_W)) bus ();

`ifdef MESH_CFG_FEEDER_STATS_EN
  logic [31:0] issue_count;
  mesh_config_feeder #(.CFG_W(CFG_W), .DEPTH(DEPTH)) dut (
    .clock(clk), .reset(rst_n), .bus(bus), .issue_count(issue_count));
`else
  mesh_config_feeder #(.CFG_W(CFG_W), .DEPTH(DEPTH)) dut (
    .clock(clk), .reset(rst_n), .bus(bus));
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: a plain queue per processor plus "waiting for accept/idle" flags.
  typedef logic [CFG_W-1:0] word_q_t[$];
  word_q_t          mq [4];
  bit               wait_accept [4];
  bit               wait_idle   [4];
  logic [CFG_W-1:0] m_cfg [4];
  logic [3:0]       m_issue;
  int               m_cnt [4];

  logic [4*CFG_W-1:0] dut_cfg;
  assign dut_cfg = {bus.p3_configure, bus.p2_configure, bus.p1_configure, bus.p0_configure};

  function automatic logic [4*CFG_W-1:0] exp_cfg();
    return {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]};
  endfunction

  function automatic logic [3:0] exp_empty();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (mq[i].size() == 0);
    return e;
  endfunction

  function automatic logic exp_load_ready();
    return mq[int'(bus.load_proc)].size() < DEPTH;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      wait_accept[i] = 0;
      wait_idle[i]   = 0;
      m_cfg[i]       = '0;
      m_cnt[i]       = 0;
    end
    m_issue = '0;
  endtask

  task automatic model_edge();
    bit acc;
    int p;
    p   = int'(bus.load_proc);
    acc = bus.load_valid && (mq[p].size() < DEPTH);
    for (int i = 0; i < 4; i++) begin
      m_issue[i] = 1'b0;
      if (wait_accept[i]) begin
        if (!bus.processor_ready_signals[i]) begin
          wait_accept[i] = 0;
          wait_idle[i]   = 1;
        end
      end else if (wait_idle[i]) begin
        if (bus.processor_ready_signals[i]) wait_idle[i] = 0;
      end else if (mq[i].size() != 0 && bus.processor_ready_signals[i]) begin
        m_cfg[i]       = mq[i].pop_front();
        m_issue[i]     = 1'b1;
        wait_accept[i] = 1;
        if (m_cnt[i] < 255) m_cnt[i]++;
      end
    end
    if (acc) mq[p].push_back(bus.load_word);
  endtask

  task automatic drive(input logic v, input logic [1:0] p, input logic [CFG_W-1:0] w,
                       input logic [3:0] r);
    bus.load_valid              = v;
    bus.load_proc               = p;
    bus.load_word               = w;
    bus.processor_ready_signals = r;
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step(input logic v, input logic [1:0] p, input logic [CFG_W-1:0] w,
                      input logic [3:0] r);
    drive(v, p, w, r);
    clk_step();
  endtask

  task automatic apply_reset(input int cycles);
    drive(1'b0, 2'd0, '0, 4'hF);
    rst_n = 1'b0;
    model_clear();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b0, 2'd0, '0, 4'hF);
    rst_n = 1'b0;
    model_clear();
    repeat (17) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (dut_cfg !== '0 || bus.issue !== 4'h0 || bus.fifo_empty !== 4'hF || bus.load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values cfg=%h issue=%b empty=%b load_ready=%b required cfg=0 issue=0000 empty=1111 load_ready=1",
               dut_cfg, bus.issue, bus.fifo_empty, bus.load_ready);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 2'd0, '0, 4'hF);
      n_checks++;
      if (dut_cfg !== '0 || bus.issue !== 4'h0 || bus.fifo_empty !== 4'hF) begin
        n_fail++;
        $display("FAIL reset_idle cycle=%0d cfg=%h issue=%b empty=%b required all zero/empty", c,
                 dut_cfg, bus.issue, bus.fifo_empty);
      end
    end
  endtask

  task automatic test_single_issue();
    logic [CFG_W-1:0] w [4];
    w[0] = 11'b00001000011; w[1] = 11'b00000100111;
    w[2] = 11'b00010000001; w[3] = 11'b01000000101;
    apply_reset(2);
    for (int p = 0; p < 4; p++) begin
      step(1'b1, 2'(p), w[p], 4'hF);
      n_checks++;
      if (bus.fifo_empty[p] !== 1'b0) begin
        n_fail++;
        $display("FAIL single_loaded_empty port=%0d got=%b required=0", p, bus.fifo_empty[p]);
      end
      step(1'b0, 2'd0, '0, 4'hF);
      n_checks++;
      if (dut_cfg[p*CFG_W +: CFG_W] !== w[p] || bus.issue !== 4'(1 << p)) begin
        n_fail++;
        $display("FAIL single_issue port=%0d cfg=%b issue=%b required cfg=%b issue=%b", p,
                 dut_cfg[p*CFG_W +: CFG_W], bus.issue, w[p], 4'(1 << p));
      end
    end
    step(1'b0, 2'd0, '0, 4'hF);
    n_checks++;
    if (bus.issue !== 4'h0 || dut_cfg !== {w[3], w[2], w[1], w[0]} || bus.fifo_empty !== 4'hF) begin
      n_fail++;
      $display("FAIL single_hold issue=%b cfg=%h empty=%b required issue=0000 cfg=%h empty=1111",
               bus.issue, dut_cfg, bus.fifo_empty, {w[3], w[2], w[1], w[0]});
    end
`ifdef MESH_CFG_FEEDER_STATS_EN
    n_checks++;
    if (issue_count !== 32'h01010101) begin
      n_fail++;
      $display("FAIL single_count got=%h required=01010101", issue_count);
    end
`endif
  endtask

  task automatic test_pacing();
    logic [CFG_W-1:0] a, b, c;
    int issues;
    a = 11'h123; b = 11'h456; c = 11'h789;
    issues = 0;
    apply_reset(2);
    step(1'b1, 2'd2, a, 4'hF); issues += int'(bus.issue[2]);
    step(1'b1, 2'd2, b, 4'hF); issues += int'(bus.issue[2]);
    step(1'b1, 2'd2, c, 4'hF); issues += int'(bus.issue[2]);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 2'd0, '0, 4'hF);
      issues += int'(bus.issue[2]);
    end
    n_checks++;
    if (issues != 1 || bus.p2_configure !== a) begin
      n_fail++;
      $display("FAIL pacing_first issues=%0d cfg=%h required issues=1 cfg=%h", issues, bus.p2_configure, a);
    end
    step(1'b0, 2'd0, '0, 4'b1011);
    step(1'b0, 2'd0, '0, 4'b1011);
    step(1'b0, 2'd0, '0, 4'hF);
    n_checks++;
    if (bus.issue !== 4'h0 || bus.p2_configure !== a) begin
      n_fail++;
      $display("FAIL pacing_rise issue=%b cfg=%h required issue=0000 cfg=%h", bus.issue, bus.p2_configure, a);
    end
    step(1'b0, 2'd0, '0, 4'hF);
    n_checks++;
    if (bus.issue !== 4'b0100 || bus.p2_configure !== b || bus.fifo_empty[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL pacing_second issue=%b cfg=%h empty2=%b required issue=0100 cfg=%h empty2=0",
               bus.issue, bus.p2_configure, bus.fifo_empty[2], b);
    end
  endtask

  task automatic test_full();
    logic [CFG_W-1:0] w [5];
    for (int k = 0; k < 5; k++) w[k] = 11'(11'h100 + 11'(k * 37));
    apply_reset(2);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'd1, w[k], 4'b1101);
      #1;
      n_checks++;
      if (bus.load_ready !== (k < 4)) begin
        n_fail++;
        $display("FAIL full_load_ready offer=%0d got=%b required=%b", k, bus.load_ready, (k < 4));
      end
      if (k == 4) begin
        bus.load_proc = 2'd0;
        #1;
        n_checks++;
        if (bus.load_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL full_other_port got=%b required=1", bus.load_ready);
        end
        bus.load_proc = 2'd1;
      end
      clk_step();
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 2'd0, '0, 4'hF);
      n_checks++;
      if (bus.issue[1] !== 1'b1 || bus.p1_configure !== w[k]) begin
        n_fail++;
        $display("FAIL full_drain word=%0d issue1=%b cfg=%h required issue1=1 cfg=%h", k,
                 bus.issue[1], bus.p1_configure, w[k]);
      end
      step(1'b0, 2'd0, '0, 4'b1101);
      step(1'b0, 2'd0, '0, 4'hF);
    end
    step(1'b0, 2'd0, '0, 4'hF);
    n_checks++;
    if (bus.issue !== 4'h0 || bus.fifo_empty !== 4'hF || bus.p1_configure !== w[3]) begin
      n_fail++;
      $display("FAIL full_dropped issue=%b empty=%b cfg=%h required issue=0000 empty=1111 cfg=%h",
               bus.issue, bus.fifo_empty, bus.p1_configure, w[3]);
    end
  endtask

  task automatic test_wrap();
    logic [CFG_W-1:0] words [10];
    int pushed, popped, bad;
    logic v;
    logic [3:0] r;
    for (int k = 0; k < 10; k++) words[k] = 11'($urandom);
    apply_reset(2);
    pushed = 0; popped = 0; bad = 0;
    for (int c = 0; c < 400 && popped < 10; c++) begin
      v = (pushed < 10) && ($urandom_range(0, 2) != 0);
      r = {($urandom_range(0, 1) == 1), 3'b111};
      drive(v, 2'd3, v ? words[pushed] : '0, r);
      if (v && mq[3].size() < DEPTH) pushed++;
      clk_step();
      if (bus.issue[3] === 1'b1) begin
        if (popped >= 10 || bus.p3_configure !== words[popped]) begin
          bad++;
          $display("FAIL wrap_order pop=%0d got=%h required=%h", popped, bus.p3_configure,
                   (popped < 10) ? words[popped] : 'x);
        end
        popped++;
      end
    end
    n_checks++;
    if (bad != 0 || popped != 10 || bus.fifo_empty[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_summary popped=%0d bad=%0d empty3=%b required popped=10 bad=0 empty3=1",
               popped, bad, bus.fifo_empty[3]);
    end
  endtask

  task automatic test_reset_mid_hold();
    int issues;
    apply_reset(2);
    step(1'b1, 2'd0, 11'h2AA, 4'hF);
    step(1'b1, 2'd0, 11'h155, 4'hF);
    step(1'b1, 2'd0, 11'h0F0, 4'hF);
    n_checks++;
    if (bus.p0_configure !== 11'h2AA || bus.fifo_empty[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midhold_setup cfg=%h empty0=%b required cfg=2aa empty0=0", bus.p0_configure, bus.fifo_empty[0]);
    end
    drive(1'b0, 2'd0, '0, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.p0_configure !== '0 || bus.fifo_empty !== 4'hF || bus.issue !== 4'h0) begin
      n_fail++;
      $display("FAIL midhold_async cfg=%h empty=%b issue=%b required cfg=0 empty=1111 issue=0000",
               bus.p0_configure, bus.fifo_empty, bus.issue);
    end
`ifdef MESH_CFG_FEEDER_STATS_EN
    n_checks++;
    if (issue_count !== 32'h0) begin
      n_fail++;
      $display("FAIL midhold_count got=%h required=00000000", issue_count);
    end
`endif
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issues = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 2'd0, '0, 4'hF);
      issues += int'(bus.issue != 4'h0);
    end
    n_checks++;
    if (issues != 0 || bus.p0_configure !== '0) begin
      n_fail++;
      $display("FAIL midhold_after issues=%0d cfg=%h required issues=0 cfg=0", issues, bus.p0_configure);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] flip;
    apply_reset(2);
    r = 4'hF;
    for (int c = 0; c < 800; c++) begin
      flip = 4'($urandom) & 4'($urandom);
      r = r ^ flip;
      drive(($urandom_range(0, 1) == 1), 2'($urandom), 11'($urandom), r);
      #1;
      n_checks++;
      if (bus.load_ready !== exp_load_ready()) begin
        n_fail++;
        $display("FAIL rand_load_ready cycle=%0d got=%b required=%b", c, bus.load_ready, exp_load_ready());
      end
      clk_step();
      n_checks++;
      if (dut_cfg !== exp_cfg() || bus.issue !== m_issue || bus.fifo_empty !== exp_empty()) begin
        n_fail++;
        $display("FAIL rand_outputs cycle=%0d cfg=%h issue=%b empty=%b required cfg=%h issue=%b empty=%b",
                 c, dut_cfg, bus.issue, bus.fifo_empty, exp_cfg(), m_issue, exp_empty());
      end
`ifdef MESH_CFG_FEEDER_STATS_EN
      n_checks++;
      if (issue_count !== {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])}) begin
        n_fail++;
        $display("FAIL rand_count cycle=%0d got=%h required=%h", c, issue_count,
                 {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])});
      end
`endif
    end
  endtask

  initial begin
    drive(1'b0, 2'd0, '0, 4'hF);
    model_clear();
    @(negedge clk);
    test_reset();
    test_single_issue();
    test_pacing();
    test_full();
    test_wrap();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mesh_config_feeder.md
# mesh_config_feeder

Upstream feeder for the 2x2 `mesh`. It queues 11-bit configuration words per processor (P0..P3) and drives them onto `p0_configure`..`p3_configure`. Each port is paced by that processor's bit of `processor_ready_signals`. It replaces the static configure registers used today, so a host can stream several jobs per processor back-to-back.

## Interface
- `CFG_W`, 11, configure word width (matches the mesh `pN_configure` ports).
- `DEPTH`, 4, per-processor FIFO depth; power of two, at least 2.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low. 0 clears all state immediately; release is synchronous to `clock`.
- `load_valid` input 1: host offers a word.
- `load_proc` input 2: target processor index, 0..3.
- `load_word` input CFG_W: configure word.
- `load_ready` output 1: the FIFO selected by `load_proc` is not full (combinational).
- `processor_ready_signals` input 4: bit i high means processor i is idle and can take a job.
- `p0_configure`, `p1_configure`, `p2_configure`, `p3_configure` output CFG_W each: registered configure words to the mesh.
- `issue` output 4: one-cycle pulse per port when a new word is presented.
- `fifo_empty` output 4: per-port FIFO empty flag.

## Operation
- Load: when `load_valid && load_ready` at a rising edge, `load_word` is written to FIFO[`load_proc`].
  - If `load_valid` is high while `load_ready` is low, the word is not written and no state changes.
- Each port i has an independent three-state FSM.
  - IDLE
    - If FIFO i is non-empty and `processor_ready_signals[i]` is 1: pop the head into `pi_configure`, assert `issue[i]` for one cycle, go to HOLD.
    - Otherwise stay in IDLE.
  - HOLD: `pi_configure` is held. When `processor_ready_signals[i]` falls to 0 (processor accepted the job), go to BUSY.
  - BUSY: when `processor_ready_signals[i]` returns to 1, go to IDLE.
    - `pi_configure` keeps the last word until the next issue.
- Simultaneous push and pop on the same FIFO in one cycle is legal.
  - The count is unchanged.
  - A push into a full FIFO in the same cycle as a pop is still refused, because `load_ready` is computed from the pre-edge count.
- Pointers are log2(DEPTH) bits plus one wrap bit.
  - Full = low bits equal and wrap bits differ.
  - Empty = both fields equal.
  - Pointers wrap modulo 2*DEPTH.
- Ports never interact; a stalled port does not block the others.

## Timing
- Reset values:
  - all `pi_configure` = 0
  - `issue` = 0
  - `fifo_empty` = 4'b1111
  - `load_ready` = 1
  - all FSMs in IDLE
  - all pointers 0
- Load-to-issue latency:
  - A word written at edge N can be issued at edge N+1 if the port is in IDLE with ready = 1.
  - `pi_configure` and `issue[i]` change after edge N+1.
- `issue[i]` is high for exactly one cycle per popped word.
- Minimum spacing between two issues on one port is 3 cycles (IDLE→HOLD→BUSY→IDLE), and requires ready to toggle 1→0→1.
- `fifo_empty[i]` updates the cycle after the push or pop edge, i.e. it is registered from the pointers.
- Reset asserted mid-operation:
  - outputs clear asynchronously and queued words are discarded;
  - after release, the first issue cannot occur before the second rising edge.

## Configuration
- Macro `MESH_CFG_FEEDER_STATS_EN`.
- Defined: adds an output `issue_count` of width 32 (4 x 8-bit fields, port i in bits [8i+7:8i]).
  - Each field increments on `issue[i]` and saturates at 255.
  - All fields reset to 0.
- Undefined: the port and the counters do not exist; all other behaviour is identical.

## Test plan
- Reset and idle:
  - Hold reset low 17 cycles, release, drive ready = 4'b1111 with no loads.
  - Required: all configure = 0, `issue` = 0, `fifo_empty` = 4'b1111 for 20 cycles.
- Single issue per port:
  - Load P0=11'b00001000011, P1=11'b00000100111, P2=11'b00010000001, P3=11'b01000000101, with ready = 1111.
  - Required: each `pi_configure` equals its word one cycle after its load, with one `issue` pulse each.
- Pacing:
  - Load three words to P2 with ready[2] = 1 held constant.
  - Required: only the first is issued.
  - Pulse ready[2] low for 2 cycles, then high: the second issues one cycle after ready rises.
- Full FIFO:
  - Load 5 words to P1 with ready[1] = 0.
  - Required: `load_ready` = 0 on the 5th offer, and that word is dropped.
  - Freeing ready afterwards issues exactly words 1..4, in order.
- Wrap:
  - Push and pop 10 words through P3 by toggling ready.
  - Required: words come out in order across pointer wrap, and `fifo_empty[3]` = 1 at the end.
- Reset mid-HOLD:
  - Assert reset while P0 is in HOLD with 2 words queued.
  - Required: `p0_configure` = 0 immediately; after release nothing issues until new loads arrive.
  - With `MESH_CFG_FEEDER_STATS_EN` defined, `issue_count` reads 0.
